// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-master memory arbiter.
package mem_arb_pkg;

  localparam int WAIT_W = 4;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_arbiter.sv
// Slot-based arbiter sharing one asynchronous-read byte RAM between the core and a DMA master.
// Each slot lasts WAIT+1 cycles; the DMA never owns two slots in a row.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WAIT = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pll_locked,
  input  logic [19:0] cpu_address,
  input  logic [7:0]  cpu_data,
  input  logic        cpu_wreq,
  output logic [7:0]  cpu_bus,
  output logic        cpu_locked,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [19:0] dma_address,
  input  logic [7:0]  dma_wdata,
  output logic        dma_ack,
  output logic [7:0]  dma_rdata,
  output logic [19:0] mem_address,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        mem_we
);

  owner_t            owner;
  logic [WAIT_W-1:0] wcnt;
  logic              last;
  logic              active;

  assign last   = (wcnt == WAIT_W'(WAIT));
  assign active = pll_locked && !reset;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      owner <= OWN_CPU;
      wcnt  <= '0;
    end else if (pll_locked) begin
      if (!last) begin
        wcnt <= wcnt + WAIT_W'(1);
      end else begin
        wcnt  <= '0;
        owner <= (owner == OWN_CPU && dma_req) ? OWN_DMA : OWN_CPU;
      end
    end
  end

  // The address/data mux follows the owner for the whole slot so the RAM sees a stable address.
  always_comb begin
    mem_address = cpu_address;
    mem_wdata   = cpu_data;
    mem_we      = 1'b0;
    if (owner == OWN_DMA) begin
      mem_address = dma_address;
      mem_wdata   = dma_wdata;
      mem_we      = active && last && dma_we;
    end else begin
      mem_we      = active && last && cpu_wreq;
    end
  end

  assign cpu_locked = active && last && (owner == OWN_CPU);
  assign dma_ack    = active && last && (owner == OWN_DMA);
  assign cpu_bus    = mem_rdata;
  assign dma_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench: three arbiter instances (WAIT = 0, 2, 3) share stimulus, each with its own RAM model.
module tb_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        pll_locked;
  logic [19:0] cpu_address;
  logic [7:0]  cpu_data;
  logic        cpu_wreq;
  logic        dma_req;
  logic        dma_we;
  logic [19:0] dma_address;
  logic [7:0]  dma_wdata;

  logic [7:0]  cpu_bus     [3];
  logic        cpu_locked  [3];
  logic        dma_ack     [3];
  logic [7:0]  dma_rdata   [3];
  logic [19:0] mem_address [3];
  logic [7:0]  mem_wdata   [3];
  logic        mem_we      [3];
  logic [7:0]  mem_rdata   [3];

  logic        tb_load;
  logic [11:0] tb_addr;
  logic [7:0]  tb_data;

  int tests = 0;
  int fails = 0;
  int cnt;

  always #5 clock = ~clock;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic [7:0] ram [4096];

    mem_arbiter #(.WAIT(g == 0 ? 0 : (g == 1 ? 2 : 3))) u_dut (
      .clock       (clock),
      .reset       (reset),
      .pll_locked  (pll_locked),
      .cpu_address (cpu_address),
      .cpu_data    (cpu_data),
      .cpu_wreq    (cpu_wreq),
      .cpu_bus     (cpu_bus[g]),
      .cpu_locked  (cpu_locked[g]),
      .dma_req     (dma_req),
      .dma_we      (dma_we),
      .dma_address (dma_address),
      .dma_wdata   (dma_wdata),
      .dma_ack     (dma_ack[g]),
      .dma_rdata   (dma_rdata[g]),
      .mem_address (mem_address[g]),
      .mem_wdata   (mem_wdata[g]),
      .mem_rdata   (mem_rdata[g]),
      .mem_we      (mem_we[g])
    );

    assign mem_rdata[g] = ram[mem_address[g][11:0]];

    always @(posedge clock) begin
      if (tb_load) ram[tb_addr] <= tb_data;
      else if (mem_we[g]) ram[mem_address[g][11:0]] <= mem_wdata[g];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1; pll_locked = 1'b1;
    cpu_address = '0; cpu_data = '0; cpu_wreq = 1'b1;
    dma_req = 1'b1; dma_we = 1'b1; dma_address = '0; dma_wdata = '0;
    tb_load = 1'b0; tb_addr = '0; tb_data = '0;

    // Reset: all strobes low even with both masters requesting writes
    step();
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst_locked%0d", k), 32'(cpu_locked[k]), 32'd0);
      check($sformatf("rst_ack%0d", k), 32'(dma_ack[k]), 32'd0);
      check($sformatf("rst_we%0d", k), 32'(mem_we[k]), 32'd0);
    end
    step();

    // WAIT=0, no DMA: core advances every cycle, address passes through
    reset = 1'b0; cpu_wreq = 1'b0; dma_req = 1'b0; dma_we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cpu_address = 20'h0ABC0 + 20'(i * 'h111);
      #1;
      check("a_locked", 32'(cpu_locked[0]), 32'd1);
      check("a_addr", 32'(mem_address[0]), 32'(20'h0ABC0 + 20'(i * 'h111)));
      step();
    end

    // WAIT=0, DMA held: D/C alternation starting with a CPU slot
    reset = 1'b1; tb_load = 1'b1; tb_addr = 12'h345; tb_data = 8'hA5;
    step();
    tb_load = 1'b0; reset = 1'b0;
    dma_req = 1'b1; dma_we = 1'b0; dma_address = 20'h12345;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("b_ack", 32'(dma_ack[0]), 32'(i % 2));
      check("b_locked", 32'(cpu_locked[0]), 32'(1 - (i % 2)));
      if (i % 2 == 1) begin
        check("b_rdata", 32'(dma_rdata[0]), 32'hA5);
        check("b_addr", 32'(mem_address[0]), 32'h12345);
      end
      step();
    end

    // WAIT=2, single DMA write of 0x5A to 0x00100
    reset = 1'b1; dma_req = 1'b0;
    step();
    reset = 1'b0; dma_req = 1'b1; dma_we = 1'b1;
    dma_address = 20'h00100; dma_wdata = 8'h5A; cpu_wreq = 1'b0; cpu_address = 20'h00777;
    for (int i = 0; i < 9; i++) begin
      if (i == 6) dma_req = 1'b0;
      #1;
      check($sformatf("c_we%0d", i), 32'(mem_we[1]), 32'(i == 5));
      check($sformatf("c_locked%0d", i), 32'(cpu_locked[1]), 32'(i == 2 || i == 8));
      check($sformatf("c_ack%0d", i), 32'(dma_ack[1]), 32'(i == 5));
      step();
    end
    check("c_ram", 32'(g_dut[1].ram[12'h100]), 32'h5A);

    // WAIT=0, core write held over two CPU slots with a DMA read stolen between
    reset = 1'b1;
    step();
    reset = 1'b0; dma_req = 1'b1; dma_we = 1'b0; dma_address = 20'h12345;
    cpu_wreq = 1'b1; cpu_address = 20'h00200; cpu_data = 8'h77; cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) cpu_wreq = 1'b0;
      #1;
      if (mem_we[0] && mem_address[0] == 20'h00200) cnt++;
      check($sformatf("d_we%0d", i), 32'(mem_we[0]), 32'(i == 0 || i == 2));
      if (i == 1) check("d_dma_addr", 32'(mem_address[0]), 32'h12345);
      step();
    end
    check("d_cpu_writes", 32'(cnt), 32'd2);
    check("d_ram", 32'(g_dut[0].ram[12'h200]), 32'h77);

    // WAIT=3, pll_locked low for 5 cycles at wcnt=1 of a CPU slot
    reset = 1'b1; dma_req = 1'b0;
    step();
    reset = 1'b0; cpu_wreq = 1'b1; cpu_address = 20'h00400; cpu_data = 8'h11;
    #1;
    check("e_locked_c0", 32'(cpu_locked[2]), 32'd0);
    step();
    pll_locked = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("e_frz_locked%0d", i), 32'(cpu_locked[2]), 32'd0);
      check($sformatf("e_frz_we%0d", i), 32'(mem_we[2]), 32'd0);
      step();
    end
    pll_locked = 1'b1;
    #1;
    check("e_locked_c6", 32'(cpu_locked[2]), 32'd0);
    step();
    #1;
    check("e_locked_c7", 32'(cpu_locked[2]), 32'd0);
    step();
    #1;
    check("e_locked_c8", 32'(cpu_locked[2]), 32'd1);
    check("e_we_c8", 32'(mem_we[2]), 32'd1);
    step();

    // WAIT=2, reset at wcnt=1 of a DMA write slot
    reset = 1'b1; cpu_wreq = 1'b0; tb_load = 1'b1; tb_addr = 12'h300; tb_data = 8'h00;
    step();
    tb_load = 1'b0; reset = 1'b0;
    dma_req = 1'b1; dma_we = 1'b1; dma_address = 20'h00300; dma_wdata = 8'h3C;
    cpu_address = 20'h00500;
    repeat (3) step();
    #1;
    check("f_dma_owner", 32'(mem_address[1]), 32'h00300);
    step();
    reset = 1'b1;
    #1;
    check("f_rst_we", 32'(mem_we[1]), 32'd0);
    check("f_rst_ack", 32'(dma_ack[1]), 32'd0);
    step();
    reset = 1'b0;
    #1;
    check("f_post_addr", 32'(mem_address[1]), 32'h00500);
    check("f_post_locked", 32'(cpu_locked[1]), 32'd0);
    check("f_post_ack", 32'(dma_ack[1]), 32'd0);
    step();
    step();
    #1;
    check("f_post_last", 32'(cpu_locked[1]), 32'd1);
    check("f_ram", 32'(g_dut[1].ram[12'h300]), 32'h00);
    dma_req = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
